// File: rtl/power_adc_scheduler.sv
// Shares one ADC between peak-power (laser-triggered) and CW conversions.
// Optional macro SAFETY_CW_AVG_EN: CW result is a 4-sample running average.
//
// Ports:
//   clk, rstn           clock, async active-low reset
//   laser_pulse         laser drive pulse; rising edge schedules a peak read
//   clear_power_fail    level; leaves FAULT back to IDLE
//   peak_delay          cycles from pulse edge to peak conversion request
//   cw_period           cycles between CW conversions, 0 = CW off
//   adc_req, adc_chan   conversion request / channel (0 peak, 1 CW)
//   adc_ack, adc_data   completion strobe and its result
//   peak_power_value    last peak result, peak_valid strobes on update
//   cw_power_value      last CW result (or average), cw_valid strobes
//   adc_timeout_fail    sticky fault, ADC never answered
`timescale 1ns/1ps

module power_adc_scheduler (
    input  logic        clk,
    input  logic        rstn,
    input  logic        laser_pulse,
    input  logic        clear_power_fail,
    input  logic [15:0] peak_delay,
    input  logic [15:0] cw_period,
    output logic        adc_req,
    output logic        adc_chan,
    input  logic        adc_ack,
    input  logic [15:0] adc_data,
    output logic [15:0] peak_power_value,
    output logic [15:0] cw_power_value,
    output logic        peak_valid,
    output logic        cw_valid,
    output logic        adc_timeout_fail
);

    typedef enum logic [2:0] {
        IDLE,
        PEAK_WAIT,
        PEAK_CONV,
        CW_CONV,
        FAULT
    } state_t;

    state_t      state, state_nx;
    logic        laser_q;
    logic        pulse_edge;
    logic        cw_expire;
    logic [15:0] dly_cnt, dly_cnt_nx;
    logic [16:0] dly_cnt_p1;
    logic [15:0] cw_cnt, cw_cnt_nx;
    logic [7:0]  wd_cnt, wd_cnt_nx;
    logic        pend_peak, pend_peak_nx;
    logic        pend_cw, pend_cw_nx;
    logic        peak_done;
    logic        cw_done;

    assign pulse_edge = laser_pulse & ~laser_q;

    // >= rather than == so a shrunk cw_period still fires promptly
    assign cw_expire = (state == IDLE) && (cw_period != 16'd0) &&
                       (cw_cnt >= cw_period - 16'd1);

    // widened so peak_delay lowered to 0 mid-wait exits at once
    assign dly_cnt_p1 = 17'(dly_cnt) + 17'd1;

    always_comb begin
        state_nx     = state;
        dly_cnt_nx   = dly_cnt;
        cw_cnt_nx    = cw_cnt;
        wd_cnt_nx    = 8'd0;
        pend_peak_nx = pend_peak;
        pend_cw_nx   = pend_cw;
        peak_done    = 1'b0;
        cw_done      = 1'b0;
        unique case (state)
            IDLE: begin
                if (cw_period != 16'd0) begin
                    cw_cnt_nx = cw_expire ? 16'd0 : cw_cnt + 16'd1;
                end
                if (pulse_edge || pend_peak) begin
                    // peak wins; a coincident CW expiry waits its turn
                    pend_peak_nx = 1'b0;
                    pend_cw_nx   = pend_cw | cw_expire;
                    dly_cnt_nx   = 16'd0;
                    state_nx     = (peak_delay == 16'd0) ? PEAK_CONV
                                                         : PEAK_WAIT;
                end else if (pend_cw || cw_expire) begin
                    pend_cw_nx = 1'b0;
                    state_nx   = CW_CONV;
                end
            end
            PEAK_WAIT: begin
                if (dly_cnt_p1 >= 17'(peak_delay)) begin
                    state_nx = PEAK_CONV;
                end else begin
                    dly_cnt_nx = dly_cnt + 16'd1;
                end
            end
            PEAK_CONV: begin
                if (adc_ack) begin
                    peak_done = 1'b1;
                    state_nx  = IDLE;
                end else if (wd_cnt == 8'd254) begin
                    pend_peak_nx = 1'b0;
                    pend_cw_nx   = 1'b0;
                    state_nx     = FAULT;
                end else begin
                    wd_cnt_nx = wd_cnt + 8'd1;
                end
            end
            CW_CONV: begin
                if (pulse_edge) begin
                    pend_peak_nx = 1'b1;
                end
                if (adc_ack) begin
                    cw_done  = 1'b1;
                    state_nx = IDLE;
                end else if (wd_cnt == 8'd254) begin
                    pend_peak_nx = 1'b0;
                    pend_cw_nx   = 1'b0;
                    state_nx     = FAULT;
                end else begin
                    wd_cnt_nx = wd_cnt + 8'd1;
                end
            end
            FAULT: begin
                if (clear_power_fail) begin
                    cw_cnt_nx = 16'd0;
                    state_nx  = IDLE;
                end
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state     <= IDLE;
            laser_q   <= 1'b0;
            dly_cnt   <= 16'd0;
            cw_cnt    <= 16'd0;
            wd_cnt    <= 8'd0;
            pend_peak <= 1'b0;
            pend_cw   <= 1'b0;
        end else begin
            state     <= state_nx;
            laser_q   <= laser_pulse;
            dly_cnt   <= dly_cnt_nx;
            cw_cnt    <= cw_cnt_nx;
            wd_cnt    <= wd_cnt_nx;
            pend_peak <= pend_peak_nx;
            pend_cw   <= pend_cw_nx;
        end
    end

    assign adc_req          = (state == PEAK_CONV) || (state == CW_CONV);
    assign adc_chan         = (state == CW_CONV);
    assign adc_timeout_fail = (state == FAULT);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            peak_power_value <= 16'd0;
            peak_valid       <= 1'b0;
            cw_valid         <= 1'b0;
        end else begin
            peak_valid <= peak_done;
            cw_valid   <= cw_done;
            if (peak_done) begin
                peak_power_value <= adc_data;
            end
        end
    end

`ifdef SAFETY_CW_AVG_EN
    logic [15:0] cw_buf [4];
    logic [17:0] cw_sum;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            cw_buf[0] <= 16'd0;
            cw_buf[1] <= 16'd0;
            cw_buf[2] <= 16'd0;
            cw_buf[3] <= 16'd0;
        end else if (cw_done) begin
            cw_buf[0] <= adc_data;
            cw_buf[1] <= cw_buf[0];
            cw_buf[2] <= cw_buf[1];
            cw_buf[3] <= cw_buf[2];
        end
    end

    // averaging over the registered buffer keeps the value aligned
    // with cw_valid, one cycle after the ack
    assign cw_sum = 18'(cw_buf[0]) + 18'(cw_buf[1]) +
                    18'(cw_buf[2]) + 18'(cw_buf[3]);
    assign cw_power_value = 16'(cw_sum >> 2);
`else
    logic [15:0] cw_raw;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            cw_raw <= 16'd0;
        end else if (cw_done) begin
            cw_raw <= adc_data;
        end
    end

    assign cw_power_value = cw_raw;
`endif

endmodule

// File: tb/tb_power_adc_scheduler.sv
// Scoreboard bench for power_adc_scheduler: an event-level reference model
// predicts requests, results and fault edges; a monitor matches the DUT.
`timescale 1ns/1ps

module tb_power_adc_scheduler;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        laser_pulse = 1'b0;
    logic        clear_power_fail = 1'b0;
    logic [15:0] peak_delay = 16'd0;
    logic [15:0] cw_period = 16'd0;
    logic        adc_ack = 1'b0;
    logic [15:0] adc_data = 16'd0;
    logic        adc_req, adc_chan;
    logic [15:0] peak_power_value, cw_power_value;
    logic        peak_valid, cw_valid, adc_timeout_fail;

    always #5 clk = ~clk;

    power_adc_scheduler dut (
        .clk              (clk),
        .rstn             (rstn),
        .laser_pulse      (laser_pulse),
        .clear_power_fail (clear_power_fail),
        .peak_delay       (peak_delay),
        .cw_period        (cw_period),
        .adc_req          (adc_req),
        .adc_chan         (adc_chan),
        .adc_ack          (adc_ack),
        .adc_data         (adc_data),
        .peak_power_value (peak_power_value),
        .cw_power_value   (cw_power_value),
        .peak_valid       (peak_valid),
        .cw_valid         (cw_valid),
        .adc_timeout_fail (adc_timeout_fail)
    );

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_cmp = 0;
    int n_bad = 0;

    localparam int K_REQ = 0, K_PV = 1, K_CV = 2, K_FR = 3, K_FF = 4;
    typedef struct {
        int kind;
        int chan;
        int data;
        int at;
    } ev_t;
    ev_t exp_q[$];

    // ---------------- reference model ----------------
    localparam int M_IDLE = 0, M_WAIT = 1, M_PCONV = 2;
    localparam int M_CCONV = 3, M_FAULT = 4;
    int m_mode, m_wait_left, m_timer, m_age;
    bit m_pend_peak, m_pend_cw, m_prev;
    int m_hist[4];

    task automatic m_reset();
        m_mode = M_IDLE;
        m_wait_left = 0;
        m_timer = 0;
        m_age = 0;
        m_pend_peak = 0;
        m_pend_cw = 0;
        m_prev = 0;
        for (int i = 0; i < 4; i++) m_hist[i] = 0;
    endtask

    task automatic push(input int kind, input int chan, input int data);
        exp_q.push_back('{kind, chan, data, cyc + 1});
    endtask

    function automatic int cw_expect(input int s);
        for (int i = 3; i > 0; i--) m_hist[i] = m_hist[i-1];
        m_hist[0] = s;
`ifdef SAFETY_CW_AVG_EN
        return (m_hist[0] + m_hist[1] + m_hist[2] + m_hist[3]) / 4;
`else
        return s;
`endif
    endfunction

    task automatic m_start_peak();
        if (peak_delay == 16'd0) begin
            m_mode = M_PCONV;
            m_age = 0;
            push(K_REQ, 0, 0);
        end else begin
            m_mode = M_WAIT;
            m_wait_left = int'(peak_delay);
        end
    endtask

    task automatic m_step(input bit lp, input bit ack,
                          input int data, input bit clr);
        bit rise, expire;
        rise = lp && !m_prev;
        m_prev = lp;
        expire = 0;
        case (m_mode)
            M_IDLE: begin
                if (cw_period != 16'd0) begin
                    if (m_timer >= int'(cw_period) - 1) begin
                        expire = 1;
                        m_timer = 0;
                    end else begin
                        m_timer++;
                    end
                end
                if (rise || m_pend_peak) begin
                    m_pend_peak = 0;
                    m_pend_cw = m_pend_cw | expire;
                    m_start_peak();
                end else if (m_pend_cw || expire) begin
                    m_pend_cw = 0;
                    m_mode = M_CCONV;
                    m_age = 0;
                    push(K_REQ, 1, 0);
                end
            end
            M_WAIT: begin
                m_wait_left--;
                if (m_wait_left == 0) begin
                    m_mode = M_PCONV;
                    m_age = 0;
                    push(K_REQ, 0, 0);
                end
            end
            M_PCONV, M_CCONV: begin
                if (m_mode == M_CCONV && rise) m_pend_peak = 1;
                if (ack) begin
                    if (m_mode == M_PCONV) push(K_PV, 0, data);
                    else push(K_CV, 1, cw_expect(data));
                    m_mode = M_IDLE;
                end else if (m_age == 254) begin
                    m_mode = M_FAULT;
                    m_pend_peak = 0;
                    m_pend_cw = 0;
                    push(K_FR, 0, 0);
                end else begin
                    m_age++;
                end
            end
            default: begin
                if (clr) begin
                    m_mode = M_IDLE;
                    m_timer = 0;
                    push(K_FF, 0, 0);
                end
            end
        endcase
    endtask

    // ---------------- monitor ----------------
    task automatic sb_check(input int kind, input int chan, input int data);
        ev_t e;
        n_cmp++;
        if (exp_q.size() == 0) begin
            n_bad++;
            $display("FAIL unexpected_event: got kind=%0d chan=%0d data=%0h at cyc %0d, want none",
                     kind, chan, data, cyc);
        end else begin
            e = exp_q[0];
            exp_q.delete(0);
            if (e.kind != kind || e.chan != chan ||
                e.data != data || e.at != cyc) begin
                n_bad++;
                $display("FAIL event_match: got kind=%0d chan=%0d data=%0h cyc=%0d, want kind=%0d chan=%0d data=%0h cyc=%0d",
                         kind, chan, data, cyc, e.kind, e.chan, e.data, e.at);
            end
        end
    endtask

    logic prv_req = 1'b0;
    logic prv_fault = 1'b0;

    always @(negedge clk) begin
        if (rstn) begin
            while (exp_q.size() > 0 && exp_q[0].at < cyc) begin
                n_cmp++;
                n_bad++;
                $display("FAIL missed_event: got none, want kind=%0d chan=%0d data=%0h at cyc %0d",
                         exp_q[0].kind, exp_q[0].chan, exp_q[0].data, exp_q[0].at);
                exp_q.delete(0);
            end
            if (adc_req && !prv_req) sb_check(K_REQ, int'(adc_chan), 0);
            if (peak_valid) sb_check(K_PV, 0, int'(peak_power_value));
            if (cw_valid) sb_check(K_CV, 1, int'(cw_power_value));
            if (adc_timeout_fail && !prv_fault) sb_check(K_FR, 0, 0);
            if (!adc_timeout_fail && prv_fault) sb_check(K_FF, 0, 0);
        end
        prv_req <= adc_req;
        prv_fault <= adc_timeout_fail;
    end

    // ---------------- stimulus ----------------
    int fix_lat = -1;
    int fix_data = -1;
    int plan_lat = 0;
    bit never_ack = 0;
    bit spurious = 0;
    int cw_seq[$];

    task automatic drive(input bit lp, input bit clr);
        bit ack;
        int d;
        ack = 0;
        d = int'($urandom_range(0, 65535));
        if (m_mode == M_PCONV || m_mode == M_CCONV) begin
            if (m_age == 0)
                plan_lat = (fix_lat >= 0) ? fix_lat
                                          : int'($urandom_range(0, 8));
            ack = !never_ack && (m_age == plan_lat);
            if (ack && fix_data >= 0) d = fix_data;
            if (ack && m_mode == M_CCONV && cw_seq.size() > 0)
                d = cw_seq.pop_front();
        end else if (spurious && $urandom_range(0, 15) == 0) begin
            ack = 1;
        end
        laser_pulse = lp;
        clear_power_fail = clr;
        adc_ack = ack;
        adc_data = 16'(d);
        m_step(lp, ack, d, clr);
        @(posedge clk);
        #1;
    endtask

    task automatic idle_n(input int n);
        for (int i = 0; i < n; i++) drive(0, 0);
    endtask

    task automatic do_reset();
        rstn = 0;
        laser_pulse = 0;
        adc_ack = 0;
        clear_power_fail = 0;
        exp_q.delete();
        repeat (2) @(posedge clk);
        #1;
        m_reset();
        rstn = 1;
    endtask

    task automatic chk(input string name, input int got, input int want);
        n_cmp++;
        if (got != want) begin
            n_bad++;
            $display("FAIL %s: got %0h, want %0h", name, got, want);
        end
    endtask

    bit lp_r;
    bit hit;

    initial begin
        m_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_adc_req", int'(adc_req), 0);
        chk("rst_adc_chan", int'(adc_chan), 0);
        chk("rst_peak_value", int'(peak_power_value), 0);
        chk("rst_cw_value", int'(cw_power_value), 0);
        chk("rst_peak_valid", int'(peak_valid), 0);
        chk("rst_cw_valid", int'(cw_valid), 0);
        chk("rst_fault", int'(adc_timeout_fail), 0);
        rstn = 1;

        // peak_delay=10, ack 3 cycles after req, data 0x1234
        peak_delay = 16'd10;
        fix_lat = 3;
        fix_data = 16'h1234;
        idle_n(3);
        drive(1, 0);
        idle_n(25);
        fix_data = -1;

        // periodic CW, then CW disabled
        fix_lat = 2;
        cw_period = 16'd100;
        idle_n(250);
        cw_period = 16'd0;
        idle_n(150);

        // averaging sequence from a clean buffer
        do_reset();
        cw_seq = '{4, 8, 12, 16};
        fix_lat = 1;
        cw_period = 16'd5;
        idle_n(36);
        cw_period = 16'd0;
        idle_n(5);

        // pulse coincident with CW expiry, then pulses during CW_CONV
        do_reset();
        peak_delay = 16'd3;
        cw_period = 16'd20;
        fix_lat = 5;
        idle_n(19);
        drive(1, 0);
        for (int i = 0; i < 80; i++)
            drive(m_mode == M_CCONV && m_age == 1, 0);

        // randomized traffic
        do_reset();
        fix_lat = -1;
        spurious = 1;
        lp_r = 0;
        for (int i = 0; i < 3000; i++) begin
            if (m_mode == M_IDLE && !m_pend_peak && !m_pend_cw &&
                $urandom_range(0, 49) == 0) begin
                peak_delay = 16'($urandom_range(0, 15));
                case ($urandom_range(0, 4))
                    0: cw_period = 16'd0;
                    1: cw_period = 16'd1;
                    2: cw_period = 16'd3;
                    3: cw_period = 16'd17;
                    default: cw_period = 16'd40;
                endcase
            end
            if ($urandom_range(0, 5) == 0) lp_r = ~lp_r;
            drive(lp_r, $urandom_range(0, 30) == 0);
        end
        idle_n(20);

        // ADC never answers: watchdog fault, ignored pulses, clear
        do_reset();
        spurious = 0;
        cw_period = 16'd0;
        peak_delay = 16'd2;
        never_ack = 1;
        drive(1, 0);
        for (int i = 0; i < 280; i++) drive(i % 40 == 5, 0);
        never_ack = 0;
        fix_lat = 2;
        drive(0, 1);
        drive(0, 1);
        drive(0, 0);
        drive(1, 0);
        idle_n(15);

        // reset in the middle of a conversion
        peak_delay = 16'd0;
        fix_lat = 20;
        drive(0, 0);
        drive(1, 0);
        hit = 0;
        for (int i = 0; i < 50 && !hit; i++) begin
            if (m_mode == M_PCONV && m_age == 2) hit = 1;
            else drive(0, 0);
        end
        chk("reach_conv", int'(hit), 1);
        rstn = 0;
        adc_ack = 0;
        laser_pulse = 0;
        #1;
        chk("reset_drops_req", int'(adc_req), 0);
        exp_q.delete();
        repeat (2) @(posedge clk);
        #1;
        m_reset();
        rstn = 1;
        idle_n(40);

        while (exp_q.size() > 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL leftover_event: got none, want kind=%0d at cyc %0d",
                     exp_q[0].kind, exp_q[0].at);
            exp_q.delete(0);
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/power_adc_scheduler.md
POWER_ADC_SCHEDULER -- requirements
Module: power_adc_scheduler

Interface
REQ-001 SHALL have clk  input  1  system clock; all logic on rising edge.
REQ-002 SHALL have rstn  input  1  reset, asynchronous, active-low.
REQ-003 SHALL have laser_pulse  input  1  laser drive pulse, synchronous to clk.
REQ-004 SHALL have clear_power_fail  input  1  level; clears the timeout fault.
REQ-005 SHALL have peak_delay  input  16  cycles from laser_pulse rising edge to peak conversion request.
REQ-006 SHALL have cw_period  input  16  cycles between CW conversions; 0 disables CW sampling.
REQ-007 SHALL have adc_req  output  1  conversion request to the shared ADC.
REQ-008 SHALL have adc_chan  output  1  ADC channel select, 0 = peak, 1 = CW.
REQ-009 SHALL have adc_ack  input  1  one-cycle ADC completion strobe; adc_data valid in the same cycle.
REQ-010 SHALL have adc_data  input  16  conversion result.
REQ-011 SHALL have peak_power_value  output  16  last peak result.
REQ-012 SHALL have cw_power_value  output  16  last CW result, averaged if configured.
REQ-013 SHALL have peak_valid and cw_valid  output  1 each  one-cycle update strobes.
REQ-014 SHALL have adc_timeout_fail  output  1  sticky ADC no-response fault.

Function
REQ-015 SHALL detect a laser_pulse rising edge as laser_pulse=1 with the previous-cycle registered value=0.
REQ-016 SHALL implement the states IDLE, PEAK_WAIT, PEAK_CONV, CW_CONV and FAULT.
REQ-017 IDLE SHALL go on an edge to PEAK_WAIT, or to PEAK_CONV if peak_delay=0.
REQ-018 PEAK_WAIT SHALL count peak_delay cycles and then enter PEAK_CONV, so adc_req rises exactly peak_delay+1 cycles after the edge cycle.
REQ-019 The CW timer SHALL count only in IDLE while cw_period!=0; on reaching cw_period-1 it SHALL enter CW_CONV and reset to 0.
REQ-020 A pulse edge and CW expiry in the same IDLE cycle SHALL take PEAK_WAIT/PEAK_CONV, and CW SHALL be held pending.
REQ-021 A pending CW SHALL be served on the next return to IDLE.
REQ-022 A pulse edge during CW_CONV SHALL set a one-deep pending-peak flag, served on the next return to IDLE ahead of pending CW, with the delay counted from service start.
REQ-023 Pulse edges during PEAK_WAIT, PEAK_CONV or FAULT SHALL be ignored.
REQ-024 In PEAK_CONV and CW_CONV, adc_req SHALL be 1 and adc_chan SHALL be stable until adc_ack.
REQ-025 In the ack cycle the result SHALL be registered; the value output and its valid SHALL update on the next cycle, with adc_req=0 on that same cycle, and the state SHALL return to IDLE.
REQ-026 adc_ack outside PEAK_CONV/CW_CONV SHALL be ignored.
REQ-027 An 8-bit watchdog SHALL count cycles in a CONV state; reaching 255 without ack SHALL enter FAULT, set adc_timeout_fail=1, drop adc_req and clear pending flags.
REQ-028 FAULT SHALL exit to IDLE, with adc_timeout_fail=0 and the CW timer at 0, on clear_power_fail=1; clear_power_fail SHALL have no effect in any other state.
REQ-029 Changes to peak_delay or cw_period SHALL take effect at the next counter load or compare.

Reset
REQ-030 On rstn=0: state IDLE, all counters and pending flags 0, adc_req=0, adc_chan=0, both values 0, both valids 0, adc_timeout_fail=0, average buffer 0.
REQ-031 Reset mid-conversion SHALL drop adc_req immediately and discard any in-flight result.

Configuration
REQ-032 With SAFETY_CW_AVG_EN defined, cw_power_value SHALL be (sum of the last 4 CW samples)>>2 using an 18-bit sum and a 4-entry buffer zeroed at reset.
REQ-033 Without SAFETY_CW_AVG_EN, cw_power_value SHALL be the raw sample and the buffer SHALL not exist; peak path timing and latency SHALL be identical in both builds.

Verification
REQ-034 peak_delay=10, pulse edge at cycle 0, ack 3 cycles after req, adc_data=0x1234 -> adc_req rises cycle 11, peak_power_value=0x1234 with peak_valid one cycle after ack.
REQ-035 cw_period=100, no pulses -> CW req (adc_chan=1) every 100 IDLE cycles plus conversion time; cw_period=0 -> no CW requests.
REQ-036 Pulse edge coincident with CW expiry -> peak served first, then CW with no intervening timer wait; pulse during CW_CONV -> served right after CW.
REQ-037 adc_ack never returned -> adc_timeout_fail=1 and adc_req=0 after 255 cycles; later pulses ignored; clear_power_fail -> IDLE, fault=0.
REQ-038 SAFETY_CW_AVG_EN defined, CW samples 4,8,12,16 -> cw_power_value 1,3,6,10; undefined -> 4,8,12,16.
